// File: rtl/inst_queue.sv
// In-order instruction queue: fetch allocates entries, memory responses fill them in
// order, decode pops the head. Flush cancels queued entries and discards late responses.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_pc,
  input  logic             req_exc,
  input  logic [4:0]       req_exccode,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_exc,
  output logic [4:0]       out_exccode,
  output logic [CNT_W-1:0] count_o,
  output logic [31:0]      perfcnt_waitack
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_inst [DEPTH];
  logic [4:0]       r_code [DEPTH];
  logic [DEPTH-1:0] r_exc, r_filled;
  logic [PW-1:0]    r_head, r_tail;
  logic [CNT_W-1:0] r_count, r_drop;
  logic [31:0]      r_perf;

  logic [PW-1:0]    w_fill;
  logic             w_has_unf, w_push, w_pop, w_ov, w_resp_drop, w_resp_fill;
  logic [CNT_W-1:0] w_unf_cnt, w_drop_base, w_drop_flush;

  // Fill pointer: oldest live entry still waiting for its response. Exception entries are
  // born filled, so they are skipped naturally.
  always_comb begin
    w_fill    = r_head;
    w_has_unf = 1'b0;
    w_unf_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count && !r_filled[r_head + PW'(i)]) begin
        w_unf_cnt = w_unf_cnt + 1'b1;
        if (!w_has_unf) begin
          w_has_unf = 1'b1;
          w_fill    = r_head + PW'(i);
        end
      end
    end
  end

  assign req_ready   = ({1'b0, r_count} + {1'b0, r_drop}) < (CNT_W+1)'(DEPTH);
  assign w_ov        = (r_count != '0) && r_filled[r_head];
  assign w_push      = req_valid && req_ready;
  assign w_pop       = w_ov && out_ready && !flush;
  assign w_resp_drop = inst_data_ok && (r_drop != '0);
  assign w_resp_fill = inst_data_ok && (r_drop == '0) && w_has_unf;
  assign w_drop_base = r_drop - CNT_W'(w_resp_drop);
  // Responses still owed to cancelled entries; one filled this cycle is no longer owed.
  assign w_drop_flush = w_drop_base + w_unf_cnt - CNT_W'(w_resp_fill)
                      + CNT_W'(w_push && !req_exc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_perf   <= '0;
      r_filled <= '0;
    end else begin
      if (w_resp_fill) begin
        r_inst[w_fill]   <= inst_rdata;
        r_filled[w_fill] <= 1'b1;
      end
      if (r_count != '0 && !r_filled[r_head] && !flush)
        r_perf <= r_perf + 32'd1;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_drop  <= w_drop_flush;
      end else begin
        r_drop <= w_drop_base;
        if (w_push) begin
          r_pc[r_tail]     <= req_pc;
          r_inst[r_tail]   <= '0;
          r_code[r_tail]   <= req_exccode;
          r_exc[r_tail]    <= req_exc;
          r_filled[r_tail] <= req_exc;
          r_tail           <= r_tail + 1'b1;
        end
        if (w_pop) r_head <= r_head + 1'b1;
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  assign out_valid       = w_ov;
  assign out_pc          = w_ov ? r_pc[r_head]   : '0;
  assign out_inst        = w_ov ? r_inst[r_head] : '0;
  assign out_exc         = w_ov ? r_exc[r_head]  : 1'b0;
  assign out_exccode     = w_ov ? r_code[r_head] : '0;
  assign count_o         = r_count;
  assign perfcnt_waitack = r_perf;
endmodule

// File: tb/tb_inst_queue.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_inst_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, req_valid, req_ready, req_exc, inst_data_ok, flush;
  logic             out_valid, out_ready, out_exc;
  logic [31:0]      req_pc, inst_rdata, out_pc, out_inst, perfcnt_waitack;
  logic [4:0]       req_exccode, out_exccode;
  logic [CNT_W-1:0] count_o;

  inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_exc(req_exc), .req_exccode(req_exccode),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_exc(out_exc), .out_exccode(out_exccode), .count_o(count_o),
    .perfcnt_waitack(perfcnt_waitack)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [4:0]  code;
    logic        filled;
  } ent_t;

  ent_t        mq[$];
  int          m_drop, m_pend;
  logic [31:0] m_perf;
  int          n_chk = 0, n_fail = 0;

  // Reference model: list of live entries, responses owed to cancelled entries, pending memory ops.
  always @(posedge clk) begin : model
    int sz, unf;
    bit rdy, ov, push, done;
    if (reset) begin
      mq.delete(); m_drop = 0; m_perf = 0; m_pend = 0;
    end else begin
      sz   = mq.size();
      rdy  = (sz + m_drop) < DEPTH;
      ov   = (sz > 0) && mq[0].filled;
      push = req_valid && rdy;
      if (sz > 0 && !mq[0].filled && !flush) m_perf = m_perf + 1;
      if (push && !req_exc) m_pend++;
      if (inst_data_ok) begin
        if (m_pend > 0) m_pend--;
        if (m_drop > 0) m_drop--;
        else begin
          done = 0;
          foreach (mq[i]) if (!done && !mq[i].filled) begin
            mq[i].inst = inst_rdata; mq[i].filled = 1'b1; done = 1;
          end
        end
      end
      if (flush) begin
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        m_drop = m_drop + unf + ((push && !req_exc) ? 1 : 0);
        mq.delete();
      end else begin
        if (ov && out_ready) void'(mq.pop_front());
        if (push) mq.push_back('{req_pc, 32'h0, req_exc, req_exccode, req_exc});
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit ov;
    ov = (mq.size() > 0) && mq[0].filled;
    cmp("count_o", 32'(count_o), mq.size());
    cmp("req_ready", 32'(req_ready), ((mq.size() + m_drop) < DEPTH) ? 1 : 0);
    cmp("out_valid", 32'(out_valid), 32'(ov));
    cmp("out_pc", out_pc, ov ? mq[0].pc : 32'h0);
    cmp("out_inst", out_inst, ov ? mq[0].inst : 32'h0);
    cmp("out_exc", 32'(out_exc), ov ? 32'(mq[0].exc) : 32'h0);
    cmp("out_exccode", 32'(out_exccode), ov ? 32'(mq[0].code) : 32'h0);
    cmp("perfcnt", perfcnt_waitack, m_perf);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic idle();
    reset = 0; req_valid = 0; req_pc = 0; req_exc = 0; req_exccode = 0;
    inst_data_ok = 0; inst_rdata = 0; flush = 0; out_ready = 0;
  endtask

  task automatic push(input logic [31:0] pc);
    req_valid = 1; req_pc = pc; cyc(); req_valid = 0;
  endtask

  task automatic resp(input logic [31:0] d);
    inst_data_ok = 1; inst_rdata = d; cyc(); inst_data_ok = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    cmp("rst_count", 32'(count_o), 0);
    cmp("rst_ready", 32'(req_ready), 1);
    cmp("rst_valid", 32'(out_valid), 0);
    cmp("rst_perf", perfcnt_waitack, 0);
    cmp("rst_pc", out_pc, 0);

    // in-order fill
    push(32'h100); push(32'h104); cyc();
    resp(32'hAAAA0001);
    cmp("s1_valid", 32'(out_valid), 1);
    cmp("s1_pc0", out_pc, 32'h100);
    cmp("s1_inst0", out_inst, 32'hAAAA0001);
    out_ready = 1; resp(32'hAAAA0002);
    cmp("s1_valid1", 32'(out_valid), 1);
    cmp("s1_pc1", out_pc, 32'h104);
    cmp("s1_inst1", out_inst, 32'hAAAA0002);
    cyc(); out_ready = 0;
    cmp("s1_empty", 32'(count_o), 0);

    // full queue
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i));
    cmp("s2_ready_full", 32'(req_ready), 0);
    cmp("s2_count_full", 32'(count_o), 4);
    resp(32'hBBBB0000);
    cmp("s2_pc", out_pc, 32'h10);
    out_ready = 1; cyc(); out_ready = 0;
    cmp("s2_ready_after", 32'(req_ready), 1);
    cmp("s2_count_after", 32'(count_o), 3);

    // flush with 3 outstanding
    flush = 1; cyc(); flush = 0;
    cmp("s3_count", 32'(count_o), 0);
    cmp("s3_model_drop", m_drop, 3);
    push(32'h200);
    cmp("s3_ready", 32'(req_ready), 0);
    for (int k = 0; k < 4; k++) begin
      resp(32'hCCCC0000 + 32'(k));
      if (k < 3) cmp("s3_no_valid", 32'(out_valid), 0);
    end
    cmp("s3_valid", 32'(out_valid), 1);
    cmp("s3_pc", out_pc, 32'h200);
    cmp("s3_inst", out_inst, 32'hCCCC0003);
    out_ready = 1; cyc(); out_ready = 0;

    // exception entry
    req_exc = 1; req_exccode = 5'h04; push(32'h300); req_exc = 0; req_exccode = 0;
    cmp("s4_valid", 32'(out_valid), 1);
    cmp("s4_exc", 32'(out_exc), 1);
    cmp("s4_code", 32'(out_exccode), 4);
    cmp("s4_pc", out_pc, 32'h300);
    out_ready = 1; cyc(); out_ready = 0;

    // flush + response + push, 1 outstanding
    push(32'h400);
    flush = 1; inst_data_ok = 1; inst_rdata = 32'hDDDD0000; req_valid = 1; req_pc = 32'h404;
    cyc(); idle();
    cmp("s5_count", 32'(count_o), 0);
    cmp("s5_model_drop", m_drop, 1);
    push(32'h500);
    resp(32'hEEEE0001);
    cmp("s5_dropped", 32'(out_valid), 0);
    resp(32'hEEEE0002);
    cmp("s5_inst", out_inst, 32'hEEEE0002);
    cmp("s5_pc", out_pc, 32'h500);
    out_ready = 1; cyc(); out_ready = 0;

    // reset mid-operation, 2 entries and 2 owed responses
    push(32'h600); push(32'h604);
    flush = 1; cyc(); flush = 0;
    push(32'h608); push(32'h60C);
    cmp("s6_count", 32'(count_o), 2);
    cmp("s6_ready", 32'(req_ready), 0);
    reset = 1; flush = 1; inst_data_ok = 1; req_valid = 1; req_pc = 32'h700;
    cyc(); idle();
    cmp("s6_rst_count", 32'(count_o), 0);
    cmp("s6_rst_ready", 32'(req_ready), 1);
    cmp("s6_rst_valid", 32'(out_valid), 0);
    cmp("s6_rst_perf", perfcnt_waitack, 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      reset        = ($urandom % 300) == 0;
      flush        = ($urandom % 25) == 0;
      req_valid    = $urandom % 2;
      req_pc       = $urandom & 32'hFFFF_FFFC;
      req_exc      = ($urandom % 8) == 0;
      req_exccode  = 5'($urandom);
      inst_data_ok = (m_pend > 0 && ($urandom % 3) != 0) || (($urandom % 40) == 0);
      inst_rdata   = $urandom;
      out_ready    = ($urandom % 3) != 0;
      cyc();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, width of occupancy and drop counters.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  fetch issues an entry (pc, exception info).
REQ-006 SHALL have port req_ready  output  1  queue can accept an entry this cycle.
REQ-007 SHALL have port req_pc  input  32  pc of the issued entry.
REQ-008 SHALL have port req_exc  input  1  entry carries a fetch exception; no memory response follows.
REQ-009 SHALL have port req_exccode  input  5  exception code of the entry.
REQ-010 SHALL have port inst_data_ok  input  1  in-order instruction memory response strobe.
REQ-011 SHALL have port inst_rdata  input  32  response data.
REQ-012 SHALL have port flush  input  1  cancel all queued and outstanding entries.
REQ-013 SHALL have port out_valid  output  1  head entry complete.
REQ-014 SHALL have port out_ready  input  1  decode consumes head.
REQ-015 SHALL have ports out_pc (32), out_inst (32), out_exc (1), out_exccode (5)  output  head entry fields.
REQ-016 SHALL have port count_o  output  CNT_W  live entries.
REQ-017 SHALL have port perfcnt_waitack  output  32  cycles head allocated but unfilled.

Function
REQ-018 SHALL store entries in a circular buffer with head, tail and fill pointers, each wrapping DEPTH-1 -> 0.
REQ-019 SHALL allocate at tail on req_valid && req_ready, recording pc, exc, exccode; filled=1 immediately if req_exc, else filled=0, inst=0.
REQ-020 SHALL drive req_ready = (count_o + drop_cnt) < DEPTH, from registered state only.
REQ-021 SHALL route inst_data_ok first to discard when drop_cnt != 0 (drop_cnt decrements, data lost).
REQ-022 SHALL otherwise write inst_rdata into the oldest allocated unfilled non-exception entry and set filled.
REQ-023 SHALL ignore inst_data_ok with drop_cnt == 0 and no unfilled entry; no state change.
REQ-024 SHALL drive out_valid = (count_o != 0) && head filled; outputs from storage, no bypass.
REQ-025 SHALL give latency: response at cycle t -> out_valid at t+1; exception entry accepted at t -> out_valid at t+1 if head.
REQ-026 SHALL pop head on out_valid && out_ready; push and pop in one cycle keep count_o unchanged.
REQ-027 SHALL on flush clear all entries (count_o=0, pointers equal) next cycle and set drop_cnt = drop_cnt + unfilled non-exception entries not filled this cycle.
REQ-028 SHALL on flush coincident with req handshake discard that entry, adding 1 to drop_cnt if req_exc=0.
REQ-029 SHALL on flush coincident with inst_data_ok apply the response first (discard or fill), then flush; a filled entry is not counted.
REQ-030 SHALL ignore pop in a flush cycle; out_valid may be high but entry is not delivered downstream.
REQ-031 SHALL keep drop_cnt <= DEPTH; new entries during drop are accepted and filled only after drop_cnt reaches 0.
REQ-032 SHALL increment perfcnt_waitack each cycle count_o != 0, head unfilled, no flush; wraps at 2^32.

Reset
REQ-033 SHALL on reset set count_o=0, drop_cnt=0, pointers=0, out_valid=0, perfcnt_waitack=0, req_ready=1.
REQ-034 SHALL give reset priority over flush, requests and responses in the same cycle; outstanding responses after reset are not tracked.
REQ-035 SHALL drive out_pc/out_inst/out_exc/out_exccode to 0 while out_valid=0 after reset.

Verification
REQ-036 SHALL cover in-order fill: push pc 0x100,0x104; responses 0xAAAA0001, 0xAAAA0002 -> out pairs in order, out_valid 1 cycle after each response.
REQ-037 SHALL cover full: DEPTH=4, 4 pushes, no responses -> req_ready=0, count_o=4; one response + pop -> req_ready=1.
REQ-038 SHALL cover flush with 3 outstanding: flush -> count_o=0, drop_cnt=3; push 0x200; 4 responses -> only 4th appears, pc 0x200.
REQ-039 SHALL cover exception entry: push req_exc=1, exccode=5'h04, pc 0x300 -> out_valid next cycle, out_exc=1, no response consumed.
REQ-040 SHALL cover simultaneous flush + response + push (req_exc=0) with 1 outstanding -> response fills then flushed, drop_cnt=1.
REQ-041 SHALL cover reset mid-operation with 2 entries and drop_cnt=2 -> all outputs at reset values next cycle.
